// File: rtl/channel_receiver.sv
// channel_receiver: receive end of the channel link.
// Takes signed channel samples, removes the mean noise bias, slices each sample back to a
// signed 2-bit symbol and buffers the symbols in a circular FIFO. Also keeps link statistics.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_chan_out     signed channel sample (W bits)
//   i_chan_valid   one-cycle strobe, i_chan_out valid this cycle
//   i_rx_ready     downstream accepts o_rx_data this cycle
//   o_rx_data      signed symbol at FIFO head (0 when empty)
//   o_rx_valid     FIFO non-empty
//   o_fifo_count   symbols currently buffered (0..DEPTH)
//   o_err_count    out-of-range sample count, saturating at 255
//   o_overrun      sticky: strobe arrived while busy
//   o_overflow     sticky: symbol dropped because the FIFO was full
//   o_busy         high while a sample is in flight (BIAS, SLICE, WRITE)
module channel_receiver #(
    parameter int W     = 14,
    parameter int AMP   = 600,
    parameter int BIAS  = 128,
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic signed [W-1:0]          i_chan_out,
    input  logic                         i_chan_valid,
    input  logic                         i_rx_ready,
    output logic [1:0]                   o_rx_data,
    output logic                         o_rx_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
    output logic [7:0]                   o_err_count,
    output logic                         o_overrun,
    output logic                         o_overflow,
    output logic                         o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Decision thresholds at full W+2 precision.
    localparam logic signed [W+1:0] BiasExt      = (W+2)'(BIAS);
    localparam logic signed [W+1:0] PosHalf      = (W+2)'(AMP / 2);
    localparam logic signed [W+1:0] NegHalf      = (W+2)'(-(AMP / 2));
    localparam logic signed [W+1:0] NegThreeHalf = (W+2)'(-((3 * AMP) / 2));
    localparam logic signed [W+1:0] PosThreeHalf = (W+2)'((3 * AMP) / 2);
    localparam logic signed [W+1:0] NegFiveHalf  = (W+2)'(-((5 * AMP) / 2));

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBias  = 2'd1,
        StSlice = 2'd2,
        StWrite = 2'd3
    } state_e;

    state_e r_state, w_state_next;

    logic signed [W-1:0] r_x;
    logic signed [W+1:0] r_y;
    logic [1:0]          r_sym;
    logic                r_range_err;
    logic [7:0]          r_err_count;
    logic                r_overrun;
    logic                r_overflow;

    logic [1:0]          r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [1:0]          w_sym;
    logic                w_range_err;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_chan_valid) w_state_next = StBias;
            StBias:  w_state_next = StSlice;
            StSlice: w_state_next = StWrite;
            StWrite: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------- Slicer ----------------
    always_comb begin
        w_sym = 2'b00;
        if (r_y >= PosHalf) begin
            w_sym = 2'b01;
        end else if (r_y >= NegHalf) begin
            w_sym = 2'b00;
        end else if (r_y >= NegThreeHalf) begin
            w_sym = 2'b11;
        end else begin
            w_sym = 2'b10;
        end
        w_range_err = (r_y > PosThreeHalf) || (r_y < NegFiveHalf);
    end

    // ---------------- Datapath and statistics ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_sym       <= 2'b00;
            r_range_err <= 1'b0;
            r_err_count <= 8'd0;
            r_overrun   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                StIdle:  if (i_chan_valid) r_x <= i_chan_out;
                StBias:  r_y <= $signed({{2{r_x[W-1]}}, r_x}) - BiasExt;
                StSlice: begin
                    r_sym       <= w_sym;
                    r_range_err <= w_range_err;
                end
                StWrite: begin
                    if (r_range_err && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: ;
            endcase
            // A strobe during a busy state is dropped; the in-flight sample continues.
            if (i_chan_valid && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- Output FIFO ----------------
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && i_rx_ready;
    assign w_push_req = (r_state == StWrite);
    // When full, a push is only possible if the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_sym;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_rx_valid   = !w_empty;
    assign o_rx_data    = w_empty ? 2'b00 : r_mem[r_rd_ptr];
    assign o_fifo_count = r_count;
    assign o_err_count  = r_err_count;
    assign o_overrun    = r_overrun;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_channel_receiver.sv
// Self-checking bench for channel_receiver: directed strobes push expected symbols into a
// scoreboard queue; a monitor pops and compares on every accepted FIFO output.
module tb_channel_receiver;

    localparam int W = 14;

    logic                clk;
    logic                rst_n;
    logic signed [W-1:0] chan_out;
    logic                chan_valid;
    logic                rx_ready;
    logic [1:0]          rx_data;
    logic                rx_valid;
    logic [3:0]          fifo_count;
    logic [7:0]          err_count;
    logic                overrun;
    logic                overflow;
    logic                busy;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    channel_receiver #(
        .W     (W),
        .AMP   (600),
        .BIAS  (128),
        .DEPTH (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_chan_out   (chan_out),
        .i_chan_valid (chan_valid),
        .i_rx_ready   (rx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_fifo_count (fifo_count),
        .o_err_count  (err_count),
        .o_overrun    (overrun),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, the pop happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got symbol %b with nothing expected", rx_data);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL sb_symbol: got %b expected %b", rx_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        rx_ready   = 1'b0;
        chan_valid = 1'b0;
        chan_out   = '0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One full 4-cycle transaction; returns in IDLE right after the push edge.
    task automatic strobe(input int val, input logic [1:0] sym, input bit keep,
                          input bit pop_in_write);
        chan_out   = W'(val);
        chan_valid = 1'b1;
        if (keep) exp_q.push_back(sym);
        @(posedge clk); #1;
        chan_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (pop_in_write) rx_ready = 1'b1;
        @(posedge clk); #1;
        if (pop_in_write) rx_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rx_ready = 1'b1;
        while (rx_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        rx_ready = 1'b0;
        chk({name, "_drained"}, int'(rx_valid), 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int vals[8];
        logic [1:0] syms[8];
        vals = '{728, 128, -472, -1072, 427, -173, 2000, -1600};
        syms = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};

        rst_n = 1'b0;
        do_reset();

        // Reset state
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);

        // Basic latency: symbol lands on the 3rd edge after the sampling edge
        chan_out = W'(728); chan_valid = 1'b1;
        exp_q.push_back(2'b01);
        @(posedge clk); #1; chan_valid = 1'b0;
        chk("lat_busy", int'(busy), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_not_yet", int'(rx_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid", int'(rx_valid), 1);
        chk("lat_data", int'(rx_data), 1);
        chk("lat_count", int'(fifo_count), 1);
        chk("lat_err", int'(err_count), 0);
        chk("lat_idle", int'(busy), 0);
        drain("basic");

        // Slicing across the thresholds, buffered then drained in order
        for (int i = 1; i < 6; i++) strobe(vals[i], syms[i], 1'b1, 1'b0);
        chk("slice_count", int'(fifo_count), 5);
        chk("slice_head", int'(rx_data), 0);
        drain("slice");
        chk("empty_data", int'(rx_data), 0);

        // Out-of-range samples still sliced; error counter saturates
        strobe(2000, 2'b01, 1'b1, 1'b0);
        chk("err_one", int'(err_count), 1);
        strobe(-1600, 2'b10, 1'b1, 1'b0);
        chk("err_two", int'(err_count), 2);
        drain("range");
        rx_ready = 1'b1;
        for (int k = 3; k <= 258; k++) begin
            strobe(((k % 2) == 1) ? 2000 : -1600, ((k % 2) == 1) ? 2'b01 : 2'b10, 1'b1, 1'b0);
            if (k == 254) chk("err_254", int'(err_count), 254);
            if (k == 255) chk("err_255", int'(err_count), 255);
        end
        chk("err_sat", int'(err_count), 255);
        drain("errsat");

        // Overrun: second strobe while in SLICE is dropped
        do_reset();
        chan_out = W'(728); chan_valid = 1'b1;
        exp_q.push_back(2'b01);
        @(posedge clk); #1; chan_valid = 1'b0;
        @(posedge clk); #1; chan_out = W'(-1072); chan_valid = 1'b1;
        @(posedge clk); #1; chan_valid = 1'b0;
        @(posedge clk); #1;
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_count", int'(fifo_count), 1);
        strobe(128, 2'b00, 1'b1, 1'b0);
        chk("ovr_next_count", int'(fifo_count), 2);
        chk("ovr_sticky", int'(overrun), 1);
        drain("overrun");

        // Overflow: 9th symbol lost when FIFO full and nothing popped
        do_reset();
        for (int i = 0; i < 8; i++) strobe(vals[i], syms[i], 1'b1, 1'b0);
        chk("full_count", int'(fifo_count), 8);
        chk("full_no_ovf", int'(overflow), 0);
        strobe(-1072, 2'b10, 1'b0, 1'b0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(fifo_count), 8);
        drain("ovf");

        // Full with simultaneous pop: 9th retained at the tail
        do_reset();
        for (int i = 0; i < 8; i++) strobe(vals[i], syms[i], 1'b1, 1'b0);
        strobe(-1072, 2'b10, 1'b1, 1'b1);
        chk("pp_no_ovf", int'(overflow), 0);
        chk("pp_count", int'(fifo_count), 8);
        drain("pushpop");

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 1; i < 4; i++) strobe(vals[i], syms[i], 1'b1, 1'b0);
        chan_out = W'(728); chan_valid = 1'b1;
        @(posedge clk); #1; chan_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_count", int'(fifo_count), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(rx_valid), 0);
        chk("arst_data", int'(rx_data), 0);
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_busy", int'(busy), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        strobe(728, 2'b01, 1'b1, 1'b0);
        chk("post_rst_count", int'(fifo_count), 1);
        chk("post_rst_data", int'(rx_data), 1);
        drain("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
